sigma_delta_decimator: RTL and testbench



---
 rtl/sigma_delta_decimator.sv | 97 +++++++++
 tb/tb_sigma_delta_decimator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_decimator.sv
// 1-bit sigma-delta bitstream to offset-binary samples through a sinc^3 CIC decimator.
// Define SDADC_SYNC_EN to put a 2-flop synchronizer in front of BITin for asynchronous sources.
module sigma_delta_decimator #(
  parameter int LOG2R = 6,
  parameter int MSBO  = 11
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CEN,
  input  logic          BITin,
  output logic          FBout,
  output logic [MSBO:0] DATAout,
  output logic          DATAvalid
);

  localparam int W     = 3*LOG2R + 1;
  localparam int SHIFT = 3*LOG2R - MSBO - 1;
  localparam int QW    = W - SHIFT;
  localparam logic [LOG2R-1:0] CNT_ONE  = 1;
  localparam logic [W-1:0]     LSB_MASK = (W'(1) << SHIFT) - W'(1);

  generate
    if (LOG2R < 2 || LOG2R > 10 || MSBO + 1 > 3*LOG2R) begin : g_param_check
      $error("sigma_delta_decimator: need 2 <= LOG2R <= 10 and MSBO+1 <= 3*LOG2R");
    end
  endgenerate

  logic acc_bit;

`ifdef SDADC_SYNC_EN
  logic [1:0] sync_ff;

  always_ff @(posedge CLK) begin
    if (RESET) sync_ff <= '0;
    else       sync_ff <= {sync_ff[0], BITin};
  end

  assign acc_bit = sync_ff[1];
`else
  assign acc_bit = BITin;
`endif

  logic [W-1:0]     i1, i2, i3, d1, d2, d3;
  logic [W-1:0]     c1, c2, c3, bit_ext;
  logic [LOG2R-1:0] cnt;
  logic [1:0]       warm;
  logic [QW-1:0]    q;
  logic [MSBO:0]    q_sat;
  logic             unused_lsbs;

  assign bit_ext = {{(W-1){1'b0}}, acc_bit};
  assign c1      = i3 - d1;
  assign c2      = c1 - d2;
  assign c3      = c2 - d3;
  assign q       = c3[W-1:SHIFT];
  // Only an all-ones input frame reaches the extra top bit; clamp it to full scale.
  assign q_sat   = q[QW-1] ? '1 : q[MSBO:0];
  assign unused_lsbs = ^(c3 & LSB_MASK);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      cnt       <= '0;
      warm      <= '0;
      FBout     <= 1'b0;
      DATAout   <= '0;
      DATAvalid <= 1'b0;
    end else begin
      DATAvalid <= 1'b0;
      if (CEN) begin
        FBout <= acc_bit;
        i1    <= i1 + bit_ext;
        i2    <= i2 + i1;
        i3    <= i3 + i2;
        cnt   <= cnt + CNT_ONE;
        // The first three ticks only prime the comb delays.
        if (cnt == '1) begin
          d1 <= i3;
          d2 <= c1;
          d3 <= c2;
          if (warm == 2'd3) begin
            DATAout   <= q_sat;
            DATAvalid <= 1'b1;
          end else begin
            warm <= warm + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Randomized self-checking bench for sigma_delta_decimator against a sinc^3 reference
// built from the bit history (cubic-weighted sums and third differences).
module tb_sigma_delta_decimator;

  localparam int LOG2R = 6;
  localparam int MSBO  = 11;
  localparam int R     = 1 << LOG2R;
  localparam int SHIFT = 3*LOG2R - MSBO - 1;
  localparam longint QMAX = (64'd1 << (MSBO+1)) - 1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        CEN = 1'b0;
  logic        BITin = 1'b0;
  logic        FBout;
  logic [11:0] DATAout;
  logic        DATAvalid;

  sigma_delta_decimator #(.LOG2R(LOG2R), .MSBO(MSBO)) dut (
    .CLK(CLK), .RESET(RESET), .CEN(CEN), .BITin(BITin),
    .FBout(FBout), .DATAout(DATAout), .DATAvalid(DATAvalid)
  );

  always #5 CLK = ~CLK;

  int testsRun = 0;
  int testsFailed = 0;

  bit          hist[$];
  longint      xs[$];
  int          nAcc;
  logic        expFb, expValid;
  logic [11:0] expData;
  logic        s1 = 1'b0, s2 = 1'b0;

  // Third integrator value before the edge that accepts bit n: sum of b_i * C(n-1-i, 2).
  function automatic longint i3At(input int n);
    longint acc;
    acc = 0;
    for (int i = 0; i < n; i++)
      if (hist[i]) acc += (longint'(n-1-i) * longint'(n-2-i)) / 2;
    return acc;
  endfunction

  task automatic applyStimulus(input logic rst, input logic cen, input logic b);
    logic   accBit;
    longint s, q;
    int     t;
    RESET = rst; CEN = cen; BITin = b;
    @(posedge CLK);
    #1;
`ifdef SDADC_SYNC_EN
    accBit = s2;
    if (rst) begin s1 = 1'b0; s2 = 1'b0; end
    else begin s2 = s1; s1 = b; end
`else
    accBit = b;
`endif
    if (rst) begin
      hist.delete(); xs.delete(); xs.push_back(0);
      nAcc = 0; expFb = 1'b0; expValid = 1'b0; expData = '0;
    end else begin
      expValid = 1'b0;
      if (cen) begin
        expFb = accBit;
        hist.push_back(accBit);
        nAcc++;
        if (nAcc % R == 0) begin
          t = nAcc / R;
          xs.push_back(i3At(nAcc - 1));
          if (t >= 4) begin
            s = xs[t] - 3*xs[t-1] + 3*xs[t-2] - xs[t-3];
            q = s >>> SHIFT;
            if (q > QMAX) q = QMAX;
            expData  = q[11:0];
            expValid = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)));
    testsRun++; if (FBout !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_fb got %b want 0", FBout); end
    testsRun++; if (DATAout !== 12'h000) begin testsFailed++; $display("[TB] FAIL reset_data got %h want 000", DATAout); end
    testsRun++; if (DATAvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got %b want 0", DATAvalid); end
  endtask

  task automatic test_zeros();
    int nValid = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 256 + 3*R; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      testsRun++;
      if (DATAvalid !== expValid || FBout !== expFb || DATAout !== expData) begin
        testsFailed++;
        $display("[TB] FAIL zeros cyc %0d got v=%b fb=%b d=%h want v=%b fb=%b d=%h", c, DATAvalid, FBout, DATAout, expValid, expFb, expData);
      end
      if (DATAvalid === 1'b1) begin
        if (nValid == 0) begin
          testsRun++;
          if (c != 256) begin testsFailed++; $display("[TB] FAIL zeros_first_valid got bit %0d want 256", c); end
        end
        nValid++;
        testsRun++;
        if (DATAout !== 12'h000) begin testsFailed++; $display("[TB] FAIL zeros_data got %h want 000", DATAout); end
      end
    end
    testsRun++; if (nValid != 4) begin testsFailed++; $display("[TB] FAIL zeros_count got %0d want 4", nValid); end
  endtask

  task automatic test_ones();
    int nValid = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 256 + 20*R; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      testsRun++;
      if (DATAvalid !== expValid || FBout !== expFb || DATAout !== expData) begin
        testsFailed++;
        $display("[TB] FAIL ones cyc %0d got v=%b fb=%b d=%h want v=%b fb=%b d=%h", c, DATAvalid, FBout, DATAout, expValid, expFb, expData);
      end
      if (DATAvalid === 1'b1) begin
        nValid++;
        testsRun++;
        if (DATAout !== 12'hFFF) begin testsFailed++; $display("[TB] FAIL ones_sat got %h want fff", DATAout); end
      end
    end
    testsRun++; if (nValid != 21) begin testsFailed++; $display("[TB] FAIL ones_count got %0d want 21", nValid); end
  endtask

  task automatic test_alternating();
    int nValid = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 256 + 4*R; c++) begin
      applyStimulus(1'b0, 1'b1, 1'(c % 2));
      testsRun++;
      if (DATAvalid !== expValid || DATAout !== expData) begin
        testsFailed++;
        $display("[TB] FAIL alternating cyc %0d got v=%b d=%h want v=%b d=%h", c, DATAvalid, DATAout, expValid, expData);
      end
      if (DATAvalid === 1'b1) begin
        nValid++;
        testsRun++;
        if (DATAout !== 12'h800) begin testsFailed++; $display("[TB] FAIL alternating_mid got %h want 800", DATAout); end
      end
    end
    testsRun++; if (nValid != 5) begin testsFailed++; $display("[TB] FAIL alternating_count got %0d want 5", nValid); end
  endtask

  task automatic test_sparse_cen();
    int lastValid = -1;
    int nValid = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 3*(256 + 3*R); c++) begin
      applyStimulus(1'b0, 1'(c % 3 == 0), 1'b1);
      testsRun++;
      if (DATAvalid !== expValid || FBout !== expFb || DATAout !== expData) begin
        testsFailed++;
        $display("[TB] FAIL sparse_cen cyc %0d got v=%b fb=%b d=%h want v=%b fb=%b d=%h", c, DATAvalid, FBout, DATAout, expValid, expFb, expData);
      end
      if (DATAvalid === 1'b1) begin
        nValid++;
        if (lastValid >= 0) begin
          testsRun++;
          if (c - lastValid != 3*R) begin testsFailed++; $display("[TB] FAIL sparse_cen_period got %0d want %0d", c - lastValid, 3*R); end
        end
        lastValid = c;
      end
    end
    testsRun++; if (nValid != 4) begin testsFailed++; $display("[TB] FAIL sparse_cen_count got %0d want 4", nValid); end
  endtask

  task automatic test_random();
    int p = 50;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 2600; c++) begin
      if (c % 200 == 1) p = $urandom_range(0, 100);
      applyStimulus(1'b0, 1'($urandom_range(0,3) != 0), 1'($urandom_range(0,99) < p));
      testsRun++;
      if (DATAvalid !== expValid || FBout !== expFb || DATAout !== expData) begin
        testsFailed++;
        $display("[TB] FAIL random cyc %0d got v=%b fb=%b d=%h want v=%b fb=%b d=%h", c, DATAvalid, FBout, DATAout, expValid, expFb, expData);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int  guard = 0;
    int  accepted = 0;
    bit  seen = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    while (!(nAcc >= 5*R && nAcc % R == 30) && guard < 1000) begin
      applyStimulus(1'b0, 1'b1, 1'($urandom_range(0,1)));
      guard++;
    end
    testsRun++;
    if (guard >= 1000) begin testsFailed++; $display("[TB] FAIL midreset_reach got %0d want cnt 30", nAcc % R); end
    applyStimulus(1'b1, 1'b1, 1'b1);
    testsRun++; if (FBout !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_fb got %b want 0", FBout); end
    testsRun++; if (DATAout !== 12'h000) begin testsFailed++; $display("[TB] FAIL midreset_data got %h want 000", DATAout); end
    testsRun++; if (DATAvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_valid got %b want 0", DATAvalid); end
    for (int c = 0; c < 400 && !seen; c++) begin
      applyStimulus(1'b0, 1'b1, 1'($urandom_range(0,1)));
      accepted++;
      if (DATAvalid === 1'b1) begin
        seen = 1;
        testsRun++;
        if (accepted != 256) begin testsFailed++; $display("[TB] FAIL midreset_latency got %0d want 256", accepted); end
        testsRun++;
        if (DATAout !== expData) begin testsFailed++; $display("[TB] FAIL midreset_data_out got %h want %h", DATAout, expData); end
      end
    end
    if (!seen) begin testsRun++; testsFailed++; $display("[TB] FAIL midreset_timeout got no valid want valid at 256"); end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_alternating();
    test_sparse_cen();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
